float_to_int_converter: RTL and testbench

- Pipelined converter from IEEE-754 single-precision float to signed 32-bit two's-complement integer. It is the inverse path of the int-to-float converter.
- Rounds toward zero, matching C cast semantics. Saturates on overflow and reports invalid/inexact flags.
- Uses a valid/ready stream on both sides and sits between the float datapath and integer consumers.

---
 rtl/float_to_int_converter.sv | 183 ++++++++++++++++++
 tb/tb_float_to_int_converter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int_converter.sv
// Three-stage IEEE-754 single to signed 32-bit integer converter, truncating toward zero.
// Saturates out-of-range values and reports invalid/inexact; one global advance drives every stage.
module float_to_int_converter #(
   parameter logic [31:0] NAN_RESULT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inValid,
   output logic        inReady,
   input  logic [31:0] inFloat,
   output logic        outValid,
   input  logic        outReady,
   output logic [31:0] outInt,
   output logic        outInvalid,
   output logic        outInexact
);

   logic advance;
   assign advance = !outValid || outReady;
   assign inReady = advance;

   // ---------------- stage 1: unpack / classify ----------------
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [22:0] in_man;
   assign in_sign = inFloat[31];
   assign in_exp  = inFloat[30:23];
   assign in_man  = inFloat[22:0];

   logic       c_nan;
   logic       c_sat;
   logic       c_min;
   logic       c_zero;
   logic       c_inexact;
   logic [4:0] c_shift;

   always_comb begin
      c_nan     = 1'b0;
      c_sat     = 1'b0;
      c_min     = 1'b0;
      c_zero    = 1'b0;
      c_inexact = 1'b0;
      // Unbiased exponent; only meaningful for the 0..30 normal range.
      c_shift   = 5'(in_exp - 8'd127);
      if (in_exp == 8'hFF) begin
         if (in_man != 23'd0) c_nan = 1'b1;
         else                 c_sat = 1'b1;
      end else if (in_exp == 8'd0) begin
         c_zero    = 1'b1;
         c_inexact = (in_man != 23'd0);
      end else if (in_exp < 8'd127) begin
         c_zero    = 1'b1;
         c_inexact = 1'b1;
      end else if (in_exp >= 8'd158) begin
         // -2^31 is the one representable value at this magnitude.
         if (in_sign && (in_exp == 8'd158) && (in_man == 23'd0)) c_min = 1'b1;
         else                                                    c_sat = 1'b1;
      end
   end

   logic        s1_valid_reg;
   logic        s1_sign_reg;
   logic        s1_nan_reg;
   logic        s1_sat_reg;
   logic        s1_min_reg;
   logic        s1_zero_reg;
   logic        s1_inexact_reg;
   logic [23:0] s1_sig_reg;
   logic [4:0]  s1_shift_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg   <= 1'b0;
         s1_sign_reg    <= 1'b0;
         s1_nan_reg     <= 1'b0;
         s1_sat_reg     <= 1'b0;
         s1_min_reg     <= 1'b0;
         s1_zero_reg    <= 1'b0;
         s1_inexact_reg <= 1'b0;
         s1_sig_reg     <= 24'd0;
         s1_shift_reg   <= 5'd0;
      end else if (advance) begin
         s1_valid_reg   <= inValid;
         s1_sign_reg    <= in_sign;
         s1_nan_reg     <= c_nan;
         s1_sat_reg     <= c_sat;
         s1_min_reg     <= c_min;
         s1_zero_reg    <= c_zero;
         s1_inexact_reg <= c_inexact;
         s1_sig_reg     <= {1'b1, in_man};
         s1_shift_reg   <= c_shift;
      end
   end

   // ---------------- stage 2: align significand ----------------
   logic [31:0] sh_mag;
   logic        sh_inexact;
   logic [4:0]  sh_right;
   logic [23:0] sh_mask;

   always_comb begin
      sh_mag     = 32'd0;
      sh_inexact = 1'b0;
      sh_right   = 5'd0;
      sh_mask    = 24'd0;
      if (s1_zero_reg) begin
         sh_inexact = s1_inexact_reg;
      end else if (s1_shift_reg >= 5'd23) begin
         sh_mag = {8'd0, s1_sig_reg} << (s1_shift_reg - 5'd23);
      end else begin
         sh_right   = 5'd23 - s1_shift_reg;
         sh_mask    = (24'd1 << sh_right) - 24'd1;
         sh_mag     = {8'd0, s1_sig_reg >> sh_right};
         sh_inexact = |(s1_sig_reg & sh_mask);
      end
   end

   logic        s2_valid_reg;
   logic        s2_sign_reg;
   logic        s2_nan_reg;
   logic        s2_sat_reg;
   logic        s2_min_reg;
   logic        s2_inexact_reg;
   logic [31:0] s2_mag_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_reg   <= 1'b0;
         s2_sign_reg    <= 1'b0;
         s2_nan_reg     <= 1'b0;
         s2_sat_reg     <= 1'b0;
         s2_min_reg     <= 1'b0;
         s2_inexact_reg <= 1'b0;
         s2_mag_reg     <= 32'd0;
      end else if (advance) begin
         s2_valid_reg   <= s1_valid_reg;
         s2_sign_reg    <= s1_sign_reg;
         s2_nan_reg     <= s1_nan_reg;
         s2_sat_reg     <= s1_sat_reg;
         s2_min_reg     <= s1_min_reg;
         s2_inexact_reg <= sh_inexact;
         s2_mag_reg     <= sh_mag;
      end
   end

   // ---------------- stage 3: sign / saturate ----------------
   logic [31:0] res_int;
   logic        res_invalid;
   logic        res_inexact;

   always_comb begin
      res_int     = s2_sign_reg ? (32'd0 - s2_mag_reg) : s2_mag_reg;
      res_invalid = 1'b0;
      res_inexact = s2_inexact_reg;
      if (s2_nan_reg) begin
         res_int     = NAN_RESULT;
         res_invalid = 1'b1;
         res_inexact = 1'b0;
      end else if (s2_sat_reg) begin
         res_int     = s2_sign_reg ? 32'h8000_0000 : 32'h7FFF_FFFF;
         res_invalid = 1'b1;
         res_inexact = 1'b0;
      end else if (s2_min_reg) begin
         res_int     = 32'h8000_0000;
         res_inexact = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         outValid   <= 1'b0;
         outInt     <= 32'd0;
         outInvalid <= 1'b0;
         outInexact <= 1'b0;
      end else if (advance) begin
         outValid   <= s2_valid_reg;
         outInt     <= res_int;
         outInvalid <= res_invalid;
         outInexact <= res_inexact;
      end
   end

endmodule

// File: tb/tb_float_to_int_converter.sv
// Directed bench for float_to_int_converter: specials, range edges, latency, backpressure and reset.
// Expected results are hand-computed and queued at input acceptance, checked at output consumption.
module tb_float_to_int_converter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [31:0] inFloat;
   logic        outValid;
   logic        outReady;
   logic [31:0] outInt;
   logic        outInvalid;
   logic        outInexact;

   float_to_int_converter dut (
      .clk        (clk),
      .reset      (reset),
      .inValid    (inValid),
      .inReady    (inReady),
      .inFloat    (inFloat),
      .outValid   (outValid),
      .outReady   (outReady),
      .outInt     (outInt),
      .outInvalid (outInvalid),
      .outInexact (outInexact)
   );

   always #5 clk = ~clk;

   int check_count = 0;
   int pass_count  = 0;
   int received    = 0;
   logic [33:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      check_count++;
      if (got === want) pass_count++;
      else $display("FAIL %s: got %h required %h", tag, got, want);
   endtask

   // One cycle: drive at the falling edge, sample 1 ns later, score the handshakes due at the next rising edge.
   task automatic step(input logic v, input logic [31:0] f, input logic [33:0] expv, input logic rdy,
                       output logic acc, output logic sv, output logic [31:0] si, output logic sr);
      logic [33:0] e;
      inValid  = v;
      inFloat  = f;
      outReady = rdy;
      #1;
      sv  = outValid;
      si  = outInt;
      sr  = inReady;
      acc = v && inReady;
      if (outValid && outReady) begin
         received++;
         $display("out int=%h invalid=%b inexact=%b", outInt, outInvalid, outInexact);
         if (exp_q.size() == 0) begin
            check("pop_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("result", outInt, e[33:2]);
            check("invalid", 32'(outInvalid), 32'(e[1]));
            check("inexact", 32'(outInexact), 32'(e[0]));
         end
      end
      if (acc) exp_q.push_back(expv);
      @(negedge clk);
   endtask

   task automatic drain();
      logic a, s, r;
      logic [31:0] i;
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         step(1'b0, 32'd0, 34'd0, 1'b1, a, s, i, r);
         n++;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   localparam int NV = 25;
   // {float, expected int, invalid, inexact}
   localparam logic [65:0] VECS [NV] = '{
      {32'h3F800000, 32'h00000001, 1'b0, 1'b0},
      {32'hC0200000, 32'hFFFFFFFE, 1'b0, 1'b1},
      {32'h4B7FFFFF, 32'h00FFFFFF, 1'b0, 1'b0},
      {32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0},
      {32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0},
      {32'hCF000000, 32'h80000000, 1'b0, 1'b0},
      {32'hCF000001, 32'h80000000, 1'b1, 1'b0},
      {32'h7FC00000, 32'h00000000, 1'b1, 1'b0},
      {32'hFF800000, 32'h80000000, 1'b1, 1'b0},
      {32'h80000000, 32'h00000000, 1'b0, 1'b0},
      {32'h00000001, 32'h00000000, 1'b0, 1'b1},
      {32'h3F000000, 32'h00000000, 1'b0, 1'b1},
      {32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0},
      {32'h7F800001, 32'h00000000, 1'b1, 1'b0},
      {32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0},
      {32'h3FC00000, 32'h00000001, 1'b0, 1'b1},
      {32'h4B000001, 32'h00800001, 1'b0, 1'b0},
      {32'h4AFFFFFF, 32'h007FFFFF, 1'b0, 1'b1},
      {32'hCB800001, 32'hFEFFFFFE, 1'b0, 1'b0},
      {32'hDF000000, 32'h80000000, 1'b1, 1'b0},
      {32'h3F7FFFFF, 32'h00000000, 1'b0, 1'b1},
      {32'h00800000, 32'h00000000, 1'b0, 1'b1},
      {32'h80400000, 32'h00000000, 1'b0, 1'b1},
      {32'h42C80000, 32'h00000064, 1'b0, 1'b0},
      {32'hC2C80000, 32'hFFFFFF9C, 1'b0, 1'b0}
   };

   // Floats 1.0 .. 10.0, all exact.
   localparam logic [31:0] STREAM [10] = '{
      32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
      32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000
   };

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc, sv, sr;
      logic [31:0] si, held;
      logic [65:0] vec;
      int          idx, rcv_base;

      reset    = 1'b1;
      inValid  = 1'b0;
      inFloat  = 32'd0;
      outReady = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(outValid), 32'd0);
      check("rst_out_int", outInt, 32'd0);
      check("rst_invalid", 32'(outInvalid), 32'd0);
      check("rst_inexact", 32'(outInexact), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_in_ready", 32'(inReady), 32'd1);

      // Latency: accept, two empty cycles, result on the third.
      step(1'b1, 32'h3F800000, {32'h00000001, 2'b00}, 1'b1, acc, sv, si, sr);
      check("lat_accept", 32'(acc), 32'd1);
      step(1'b0, 32'd0, 34'd0, 1'b1, acc, sv, si, sr);
      check("lat_cycle1", 32'(sv), 32'd0);
      step(1'b0, 32'd0, 34'd0, 1'b1, acc, sv, si, sr);
      check("lat_cycle2", 32'(sv), 32'd0);
      step(1'b0, 32'd0, 34'd0, 1'b1, acc, sv, si, sr);
      check("lat_cycle3", 32'(sv), 32'd1);
      drain();

      // Directed vectors back to back.
      for (int i = 0; i < NV; i++) begin
         vec = VECS[i];
         step(1'b1, vec[65:34], vec[33:0], 1'b1, acc, sv, si, sr);
         check("vec_accept", 32'(acc), 32'd1);
      end
      drain();

      // Backpressure: outReady low on cycles 4..8.
      rcv_base = received;
      idx = 0;
      held = 32'd0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (idx < 10)
            step(1'b1, STREAM[idx], {32'(idx + 1), 2'b00}, !(cyc >= 4 && cyc <= 8), acc, sv, si, sr);
         else
            step(1'b0, 32'd0, 34'd0, 1'b1, acc, sv, si, sr);
         if (cyc >= 4 && cyc <= 8) begin
            check("stall_in_ready", 32'(sr), 32'd0);
            check("stall_out_valid", 32'(sv), 32'd1);
            if (cyc == 4) held = si;
            else check("stall_hold", si, held);
         end
         if (cyc >= 9 && (received - rcv_base) < 10) check("b2b_valid", 32'(sv), 32'd1);
         if (acc) idx++;
         if (idx == 10 && exp_q.size() == 0) break;
      end
      check("stream_count", 32'(received - rcv_base), 32'd10);
      check("stall_held_value", held, 32'd2);

      // Reset with all three stages occupied.
      step(1'b1, 32'h40000000, {32'd2, 2'b00}, 1'b1, acc, sv, si, sr);
      step(1'b1, 32'h40400000, {32'd3, 2'b00}, 1'b1, acc, sv, si, sr);
      step(1'b1, 32'h40800000, {32'd4, 2'b00}, 1'b1, acc, sv, si, sr);
      reset = 1'b1;
      step(1'b0, 32'd0, 34'd0, 1'b0, acc, sv, si, sr);
      check("pre_rst_full", 32'(sv), 32'd1);
      #1;
      check("mid_rst_out_valid", 32'(outValid), 32'd0);
      check("mid_rst_out_int", outInt, 32'd0);
      check("mid_rst_invalid", 32'(outInvalid), 32'd0);
      check("mid_rst_inexact", 32'(outInexact), 32'd0);
      exp_q.delete();
      reset = 1'b0;
      @(negedge clk);
      rcv_base = received;
      step(1'b1, 32'h41100000, {32'd9, 2'b00}, 1'b1, acc, sv, si, sr);
      check("post_rst_accept", 32'(acc), 32'd1);
      step(1'b0, 32'd0, 34'd0, 1'b1, acc, sv, si, sr);
      check("post_rst_cycle1", 32'(sv), 32'd0);
      step(1'b0, 32'd0, 34'd0, 1'b1, acc, sv, si, sr);
      check("post_rst_cycle2", 32'(sv), 32'd0);
      step(1'b0, 32'd0, 34'd0, 1'b1, acc, sv, si, sr);
      check("post_rst_cycle3", 32'(sv), 32'd1);
      check("post_rst_count", 32'(received - rcv_base), 32'd1);
      drain();

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
